// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control units: opcodes, datapath mux selects and
// the multi-cycle state enum. Imported by both the single-cycle and multi-cycle decoders.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_I_EXEC   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_ADDI) ||
               (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from FSM state, opcode and mem_ready.
// Build option ILLEGAL_OP_TRAP_EN enables the TRAP state outputs.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic [1:0] o_mem_to_reg,
    output logic [1:0] o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_instr_done
);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = M2R_ALUOUT;
        o_reg_dst       = RDST_RT;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_RT;
        o_alu_op        = ALUOP_ADD;
        o_pc_source     = PCSRC_ALU;
        o_instr_done    = 1'b0;
        case (state_t'(i_state))
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH2;
`ifndef ILLEGAL_OP_TRAP_EN
                // Illegal opcodes retire here as a NOP when trapping is disabled.
                o_instr_done = !is_legal_op(i_opcode);
`endif
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = M2R_MDR;
                o_instr_done = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_write  = 1'b1;
                o_i_or_d     = 1'b1;
                o_instr_done = i_mem_ready;
            end
            S_R_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_I_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                if (i_opcode == OP_ANDI)     o_alu_op = ALUOP_AND;
                else if (i_opcode == OP_ORI) o_alu_op = ALUOP_OR;
                else                         o_alu_op = ALUOP_ADD;
            end
            S_ALU_WB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = (i_opcode == OP_RTYPE) ? RDST_RD : RDST_RT;
                o_instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
                o_instr_done    = 1'b1;
            end
            S_JAL: begin
                o_pc_write   = 1'b1;
                o_pc_source  = PCSRC_JUMP;
                o_reg_write  = 1'b1;
                o_reg_dst    = RDST_RA;
                o_mem_to_reg = M2R_PC;
                o_instr_done = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_EXC;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath, stalls on mem_ready,
// counts retired instructions. Build option ILLEGAL_OP_TRAP_EN routes illegal opcodes to TRAP.
// state | meaning: IDLE post-reset | FETCH IR load | DECODE reg read, branch target
//   MEM_ADDR/MEM_RD/MEM_WB lw, MEM_WR sw | R_EXEC/I_EXEC ALU op, ALU_WB writeback
//   BRANCH beq compare | JAL jump and link | TRAP illegal opcode vector
module mc_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          MemToReg,
    output logic [1:0]          RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                instr_done,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic [3:0]          state_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [2:0]       w_alu_op;
    logic             w_instr_done;

    mc_output_decode u_decode (
        .i_state         (r_state),
        .i_opcode        (opcode),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (PCWrite),
        .o_pc_write_cond (PCWriteCond),
        .o_i_or_d        (IorD),
        .o_mem_read      (MemRead),
        .o_mem_write     (MemWrite),
        .o_ir_write      (IRWrite),
        .o_mem_to_reg    (MemToReg),
        .o_reg_dst       (RegDst),
        .o_reg_write     (RegWrite),
        .o_alu_src_a     (ALUSrcA),
        .o_alu_src_b     (ALUSrcB),
        .o_alu_op        (w_alu_op),
        .o_pc_source     (PCSource),
        .o_instr_done    (w_instr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_retire_cnt <= '0;
        end else begin
            if (w_instr_done) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE:     r_state <= S_FETCH;
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:            r_state <= S_MEM_ADDR;
                        OP_RTYPE:                r_state <= S_R_EXEC;
                        OP_ADDI, OP_ANDI, OP_ORI: r_state <= S_I_EXEC;
                        OP_BEQ:                  r_state <= S_BRANCH;
                        OP_JAL:                  r_state <= S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:                 r_state <= S_TRAP;
`else
                        default:                 r_state <= S_FETCH;
`endif
                    endcase
                end
                S_MEM_ADDR: r_state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
                S_R_EXEC:   r_state <= S_ALU_WB;
                S_I_EXEC:   r_state <= S_ALU_WB;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    assign ALUOp      = ALUOP_W'(w_alu_op);
    assign instr_done = w_instr_done;
    assign retire_cnt = r_retire_cnt;
    assign state_o    = r_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: per-instruction expected state paths and
// control words built from the instruction rules, plus a 4-bit counter instance for wrap.
module tb_mc_control_unit;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04;
    localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D, JAL = 6'h03;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'h00;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, instr_done;
    logic [1:0]  MemToReg, RegDst, ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [31:0] retire_cnt;
    logic [3:0]  state_o;

    logic        pcw4, pcwc4, iord4, mrd4, mwr4, irw4, rw4, srca4, done4;
    logic [1:0]  m2r4, rdst4, srcb4, pcs4;
    logic [2:0]  aop4;
    logic [3:0]  retire_cnt4;
    logic [3:0]  state4;

    mc_control_unit u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .retire_cnt(retire_cnt), .state_o(state_o)
    );

    mc_control_unit #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw4), .PCWriteCond(pcwc4), .IorD(iord4), .MemRead(mrd4),
        .MemWrite(mwr4), .IRWrite(irw4), .MemToReg(m2r4), .RegDst(rdst4),
        .RegWrite(rw4), .ALUSrcA(srca4), .ALUSrcB(srcb4), .ALUOp(aop4),
        .PCSource(pcs4), .instr_done(done4), .retire_cnt(retire_cnt4), .state_o(state4)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned model_cnt = 0;
    int          st_q[$];
    bit          rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, ADDI, ANDI, ORI, JAL};
    endfunction

    function automatic logic [19:0] obs_word();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};
    endfunction

    // Expected control word for a given state number, following the per-state output rules.
    function automatic logic [19:0] exp_word(input int st, input logic [5:0] op, input bit rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, srca, done;
        logic [1:0] m2r, rdst, srcb, pcs;
        logic [2:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, rw, srca, done} = '0;
        {m2r, rdst, srcb, pcs, aop} = '0;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin srcb = 2'b11; done = !legal(op) && !TRAP_ON; end
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 2'b01; done = 1; end
            6:  begin mwr = 1; iord = 1; done = rdy; end
            7:  begin srca = 1; aop = 3'b010; end
            8:  begin srca = 1; srcb = 2'b10; aop = (op == ANDI) ? 3'b011 : (op == ORI) ? 3'b100 : 3'b000; end
            9:  begin rw = 1; done = 1; rdst = (op == RT) ? 2'b01 : 2'b00; end
            10: begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; done = 1; end
            11: begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; done = 1; end
            12: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, done};
    endfunction

    task automatic push_step(input int st, input bit rdy);
        st_q.push_back(st);
        rd_q.push_back(rdy);
    endtask

    // Runs one instruction from FETCH; fw = fetch wait cycles, mw = memory wait cycles.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        st_q.delete();
        rd_q.delete();
        for (int i = 0; i < fw; i++) push_step(1, 1'b0);
        push_step(1, 1'b1);
        push_step(2, 1'($urandom));
        if (op == LW) begin
            push_step(3, 1'($urandom));
            for (int i = 0; i < mw; i++) push_step(4, 1'b0);
            push_step(4, 1'b1);
            push_step(5, 1'($urandom));
        end else if (op == SW) begin
            push_step(3, 1'($urandom));
            for (int i = 0; i < mw; i++) push_step(6, 1'b0);
            push_step(6, 1'b1);
        end else if (op == RT) begin
            push_step(7, 1'($urandom));
            push_step(9, 1'($urandom));
        end else if (op inside {ADDI, ANDI, ORI}) begin
            push_step(8, 1'($urandom));
            push_step(9, 1'($urandom));
        end else if (op == BEQ) begin
            push_step(10, 1'($urandom));
        end else if (op == JAL) begin
            push_step(11, 1'($urandom));
        end else if (TRAP_ON) begin
            push_step(12, 1'($urandom));
        end
        opcode = op;
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ready = rd_q[i];
            #1;
            check($sformatf("state op=%0h cyc=%0d", op, i), 32'(state_o), 32'(st_q[i]));
            check($sformatf("ctrl op=%0h st=%0d", op, st_q[i]), 32'(obs_word()),
                  32'(exp_word(st_q[i], op, rd_q[i])));
            @(posedge clk);
            #1;
        end
        if (legal(op) || !TRAP_ON) model_cnt++;
        check($sformatf("retire op=%0h", op), retire_cnt, 32'(model_cnt));
        check($sformatf("retire4 op=%0h", op), 32'(retire_cnt4), 32'(model_cnt % 16));
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] ops [8];
        ops = '{LW, SW, RT, BEQ, ADDI, ANDI, ORI, JAL};

        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(state_o), 32'd0);
        check("reset ctrl", 32'(obs_word()), 32'd0);
        check("reset cnt", retire_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle ctrl", 32'(obs_word()), 32'd0);
        @(posedge clk);
        #1;
        check("post-reset state", 32'(state_o), 32'd1);

        for (int i = 0; i < 16; i++) run_instr(BEQ, 0, 0);
        check("wrap cnt4", 32'(retire_cnt4), 32'd0);
        check("cnt after 16 beq", retire_cnt, 32'd16);

        run_instr(LW, 0, 0);
        run_instr(SW, 0, 3);
        run_instr(RT, 0, 0);
        run_instr(ORI, 1, 0);
        run_instr(JAL, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(ADDI, 2, 0);
        run_instr(ANDI, 0, 0);
        run_instr(LW, 1, 2);

        // Abort a lw while it waits in MEM_RD.
        opcode = LW;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("pre-abort state", 32'(state_o), 32'd4);
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        check("abort state", 32'(state_o), 32'd0);
        check("abort ctrl", 32'(obs_word()), 32'd0);
        check("abort cnt", retire_cnt, 32'd0);
        check("abort cnt4", 32'(retire_cnt4), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart state", 32'(state_o), 32'd1);
        check("restart MemRead", 32'(MemRead), 32'd1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 8) == 8) begin
                rop = 6'($urandom);
                while (legal(rop)) rop = 6'($urandom);
            end else begin
                rop = ops[$urandom_range(0, 7)];
            end
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
